// File: rtl/lsu_byte_master.sv
// Byte-serial load/store master: one RISC-V load/store becomes 1/2/4 little-endian byte accesses.
// Optional macro LSU_BYTE_MASTER_MISALIGN_TRAP_EN reports misaligned H/W requests via resp_err without touching memory.
module lsu_byte_master #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int STORE_WIDTH   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [2:0]               req_funct3,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     resp_valid,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     resp_err,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [STORE_WIDTH-1:0]   mem_wd,
  input  logic [STORE_WIDTH-1:0]   mem_rd,
  output logic [1:0]               dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, and resp_valid is a one-cycle pulse with no backpressure.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_next_state;
  logic                     r_we;
  logic [2:0]               r_funct3;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic [DATA_WIDTH-1:0]    r_rbuf;
  logic [1:0]               r_cnt;
  logic [1:0]               w_last_idx;
  logic                     w_last;
  logic                     w_accept;
  logic                     w_misalign;
  logic                     w_err;

  assign w_accept  = req_valid && (r_state == S_IDLE);
  assign dbg_state = r_state;

  always_comb begin
    w_last_idx = 2'd3;
    case (r_funct3[1:0])
      2'b00:   w_last_idx = 2'd0;
      2'b01:   w_last_idx = 2'd1;
      default: w_last_idx = 2'd3;
    endcase
  end

  assign w_last = (r_cnt == w_last_idx);

`ifdef LSU_BYTE_MASTER_MISALIGN_TRAP_EN
  logic r_err;

  assign w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      (req_funct3[1] && (req_addr[1:0] != 2'b00));
  assign w_err      = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= w_misalign;
    end
  end
`else
  assign w_misalign = 1'b0;
  assign w_err      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rbuf   <= '0;
      r_cnt    <= 2'd0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_rbuf   <= '0;
            r_cnt    <= 2'd0;
          end
        end
        S_XFER: begin
          if (!r_we) begin
            r_rbuf[{r_cnt, 3'b000} +: STORE_WIDTH] <= mem_rd;
          end
          if (!w_last) begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next_state = r_state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_rdata   = '0;
    resp_err     = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wd       = '0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (w_accept) begin
          w_next_state = w_misalign ? S_RESP : S_XFER;
        end
      end
      S_XFER: begin
        // Address arithmetic wraps naturally at 2^ADDRESS_WIDTH.
        mem_addr = r_addr + {{(ADDRESS_WIDTH-2){1'b0}}, r_cnt};
        mem_we   = r_we;
        if (r_we) begin
          mem_wd = r_wdata[{r_cnt, 3'b000} +: STORE_WIDTH];
        end
        if (w_last) begin
          w_next_state = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid   = 1'b1;
        resp_err     = w_err;
        w_next_state = S_IDLE;
        if (!r_we && !w_err) begin
          case (r_funct3[1:0])
            2'b00:   resp_rdata = {{(DATA_WIDTH-8){~r_funct3[2] & r_rbuf[7]}}, r_rbuf[7:0]};
            2'b01:   resp_rdata = {{(DATA_WIDTH-16){~r_funct3[2] & r_rbuf[15]}}, r_rbuf[15:0]};
            default: resp_rdata = r_rbuf;
          endcase
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

endmodule
